// File: rtl/ps2_move_decoder.sv
// ps2_move_decoder
// Turns the PS/2 scan-code set 2 byte stream into buffered, de-duplicated
// player-move tokens. It handles the make, break and extended (0xE0)
// sequences. Typematic repeats of the currently held key are dropped.
// Each accepted move is queued in a small circular FIFO. The consumer
// drains the FIFO through a valid/ready handshake.
//
// Configuration macro: PS2_MOVE_WASD_EN
//   defined   - non-extended W/S/A/D make codes are also moves
//   undefined - only the extended arrow keys produce moves
//
// Ports:
//   CLOCK_50        in   system clock, rising edge
//   resetn          in   synchronous active-low reset
//   ps2_key_pressed in   one-cycle strobe qualifying ps2_key_data
//   ps2_key_data    in   received PS/2 byte
//   flush           in   clears FIFO, held key and partial sequence (not overflow)
//   move_ready      in   consumer takes the head token this cycle
//   move_valid      out  FIFO non-empty
//   move_dir        out  head token: 00 up, 01 down, 10 left, 11 right
//   start_pulse     out  one-cycle pulse on an Enter make code (0x5A)
//   fifo_count      out  number of occupied FIFO entries
//   overflow        out  sticky, set when a token is dropped on a full FIFO
module ps2_move_decoder #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  ps2_key_pressed,
    input  logic [7:0]            ps2_key_data,
    input  logic                  flush,
    input  logic                  move_ready,
    output logic                  move_valid,
    output logic [1:0]            move_dir,
    output logic                  start_pulse,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO   = (DEPTH_LOG2 + 1)'(0);
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_EXT     = 2'b01,
        S_BRK     = 2'b10,
        S_EXT_BRK = 2'b11
    } state_t;

    // Returns {hit, dir} for an extended arrow-key code.
    function automatic logic [2:0] arrow_lookup(input logic [7:0] code);
        case (code)
            8'h75:   return 3'b100;
            8'h72:   return 3'b101;
            8'h6B:   return 3'b110;
            8'h74:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

`ifdef PS2_MOVE_WASD_EN
    // Returns {hit, dir} for a non-extended W/S/A/D code.
    function automatic logic [2:0] wasd_lookup(input logic [7:0] code);
        case (code)
            8'h1D:   return 3'b100;
            8'h1B:   return 3'b101;
            8'h1C:   return 3'b110;
            8'h23:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction
`endif

    state_t                r_state, w_state_nxt;
    logic                  r_held_valid, w_held_valid;
    logic                  r_held_ext, w_held_ext;
    logic [7:0]            r_held_code, w_held_code;
    logic                  r_push_req, w_push;
    logic [1:0]            r_push_dir, w_push_dir;
    logic                  r_start, w_start;
    logic                  w_make, w_make_ext;
    logic [1:0]            w_make_dir;
    logic [2:0]            w_lookup;

    logic [1:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic                  w_pop, w_full, w_wr, w_drop;

    // Decoder next-state, make-code detection and held-key filtering
    always_comb begin
        w_state_nxt  = r_state;
        w_held_valid = r_held_valid;
        w_held_ext   = r_held_ext;
        w_held_code  = r_held_code;
        w_start      = 1'b0;
        w_make       = 1'b0;
        w_make_ext   = 1'b0;
        w_make_dir   = 2'b00;
        w_lookup     = 3'b000;
        w_push       = 1'b0;
        w_push_dir   = 2'b00;

        if (ps2_key_pressed) begin
            case (r_state)
                S_IDLE: begin
                    if (ps2_key_data == 8'hE0) begin
                        w_state_nxt = S_EXT;
                    end else if (ps2_key_data == 8'hF0) begin
                        w_state_nxt = S_BRK;
                    end else if (ps2_key_data == 8'h5A) begin
                        w_start = 1'b1;
                    end else begin
`ifdef PS2_MOVE_WASD_EN
                        w_lookup   = wasd_lookup(ps2_key_data);
                        w_make     = w_lookup[2];
                        w_make_dir = w_lookup[1:0];
`else
                        w_make     = 1'b0;
`endif
                    end
                end
                S_EXT: begin
                    if (ps2_key_data == 8'hF0) begin
                        w_state_nxt = S_EXT_BRK;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_lookup    = arrow_lookup(ps2_key_data);
                        w_make      = w_lookup[2];
                        w_make_ext  = 1'b1;
                        w_make_dir  = w_lookup[1:0];
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    // Releasing the held key re-arms it. Releases of other keys are ignored.
                    w_state_nxt = S_IDLE;
                    if (r_held_valid && (r_held_ext == (r_state == S_EXT_BRK)) &&
                        (r_held_code == ps2_key_data)) begin
                        w_held_valid = 1'b0;
                    end else begin
                        w_held_valid = r_held_valid;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end

        // A make code for the key already held is a typematic repeat.
        if (w_make && !(r_held_valid && (r_held_ext == w_make_ext) &&
                        (r_held_code == ps2_key_data))) begin
            w_push       = 1'b1;
            w_push_dir   = w_make_dir;
            w_held_valid = 1'b1;
            w_held_ext   = w_make_ext;
            w_held_code  = ps2_key_data;
        end else begin
            w_push       = 1'b0;
        end
    end

    // Decoder state, held key and the staged push/start strobes
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_held_valid <= 1'b0;
            r_held_ext   <= 1'b0;
            r_held_code  <= 8'h00;
            r_push_req   <= 1'b0;
            r_push_dir   <= 2'b00;
            r_start      <= 1'b0;
        end else if (flush) begin
            r_state      <= S_IDLE;
            r_held_valid <= 1'b0;
            r_held_ext   <= 1'b0;
            r_held_code  <= 8'h00;
            r_push_req   <= 1'b0;
            r_push_dir   <= 2'b00;
            r_start      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_held_valid <= w_held_valid;
            r_held_ext   <= w_held_ext;
            r_held_code  <= w_held_code;
            r_push_req   <= w_push;
            r_push_dir   <= w_push_dir;
            r_start      <= w_start;
        end
    end

    assign w_full = (r_count == FULL_COUNT);
    assign w_pop  = move_valid & move_ready;
    // Writing into a full FIFO is allowed when the head leaves the same cycle.
    assign w_wr   = r_push_req & (~w_full | w_pop);
    assign w_drop = r_push_req & w_full & ~w_pop;

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= CNT_ZERO;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= CNT_ZERO;
            r_overflow <= r_overflow;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            else      r_wr_ptr <= r_wr_ptr;
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            else       r_rd_ptr <= r_rd_ptr;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_overflow <= r_overflow | w_drop;
        end
    end

    // FIFO storage
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 2'b00;
        end else if (!flush && w_wr) begin
            r_mem[r_wr_ptr] <= r_push_dir;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    assign move_valid  = (r_count != CNT_ZERO);
    assign move_dir    = r_mem[r_rd_ptr];
    assign fifo_count  = r_count;
    assign overflow    = r_overflow;
    assign start_pulse = r_start;

endmodule

// File: tb/tb_ps2_move_decoder.sv
module tb_ps2_move_decoder;

    logic       CLOCK_50;
    logic       resetn;
    logic       ps2_key_pressed;
    logic [7:0] ps2_key_data;
    logic       flush;
    logic       move_ready;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       start_pulse;
    logic [2:0] fifo_count;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    ps2_move_decoder #(.DEPTH_LOG2(2)) dut (
        .CLOCK_50        (CLOCK_50),
        .resetn          (resetn),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_key_data    (ps2_key_data),
        .flush           (flush),
        .move_ready      (move_ready),
        .move_valid      (move_valid),
        .move_dir        (move_dir),
        .start_pulse     (start_pulse),
        .fifo_count      (fifo_count),
        .overflow        (overflow)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [1:0] mq[$];
    bit         m_known = 1'b0;
    bit         m_pend;
    bit  [1:0]  m_pend_dir;
    bit         m_start;
    bit         m_ovf;
    bit         m_held_v, m_held_ext;
    bit  [7:0]  m_held_code;
    bit         m_pre_ext, m_pre_brk;

    function automatic bit key_dir(input bit ext, input bit [7:0] d, output bit [1:0] dir);
        dir = 2'd0;
        if (ext) begin
            case (d)
                8'h75: begin dir = 2'd0; return 1'b1; end
                8'h72: begin dir = 2'd1; return 1'b1; end
                8'h6B: begin dir = 2'd2; return 1'b1; end
                8'h74: begin dir = 2'd3; return 1'b1; end
                default: return 1'b0;
            endcase
        end
`ifdef PS2_MOVE_WASD_EN
        case (d)
            8'h1D: begin dir = 2'd0; return 1'b1; end
            8'h1B: begin dir = 2'd1; return 1'b1; end
            8'h1C: begin dir = 2'd2; return 1'b1; end
            8'h23: begin dir = 2'd3; return 1'b1; end
            default: return 1'b0;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge CLOCK_50) begin
        bit [1:0] dir;
        bit       hit;
        if (!resetn) begin
            mq.delete();
            m_known = 1'b1;
            m_pend = 1'b0; m_start = 1'b0; m_ovf = 1'b0;
            m_held_v = 1'b0; m_pre_ext = 1'b0; m_pre_brk = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_pend = 1'b0; m_start = 1'b0;
            m_held_v = 1'b0; m_pre_ext = 1'b0; m_pre_brk = 1'b0;
        end else begin
            if (mq.size() > 0 && move_ready) void'(mq.pop_front());
            if (m_pend) begin
                if (mq.size() < 4) mq.push_back(m_pend_dir);
                else m_ovf = 1'b1;
            end
            m_pend  = 1'b0;
            m_start = 1'b0;
            if (ps2_key_pressed) begin
                if (m_pre_brk) begin
                    if (m_held_v && m_held_ext == m_pre_ext && m_held_code == ps2_key_data)
                        m_held_v = 1'b0;
                    m_pre_brk = 1'b0;
                    m_pre_ext = 1'b0;
                end else if (ps2_key_data == 8'hF0) begin
                    m_pre_brk = 1'b1;
                end else if (!m_pre_ext && ps2_key_data == 8'hE0) begin
                    m_pre_ext = 1'b1;
                end else begin
                    if (!m_pre_ext && ps2_key_data == 8'h5A) m_start = 1'b1;
                    hit = key_dir(m_pre_ext, ps2_key_data, dir);
                    if (hit && !(m_held_v && m_held_ext == m_pre_ext && m_held_code == ps2_key_data)) begin
                        m_pend      = 1'b1;
                        m_pend_dir  = dir;
                        m_held_v    = 1'b1;
                        m_held_ext  = m_pre_ext;
                        m_held_code = ps2_key_data;
                    end
                    m_pre_ext = 1'b0;
                end
            end
        end
    end

    // Compare DUT outputs with the model on every falling edge
    always @(negedge CLOCK_50) begin
        if (m_known) begin
            check("model_valid", move_valid, (mq.size() != 0));
            check("model_count", fifo_count, mq.size());
            check("model_overflow", overflow, m_ovf);
            check("model_start", start_pulse, m_start);
            if (mq.size() != 0) check("model_dir", move_dir, mq[0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit p, input logic [7:0] d, input bit r, input bit f);
        ps2_key_pressed = p;
        ps2_key_data    = d;
        move_ready      = r;
        flush           = f;
        @(negedge CLOCK_50);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic key2(input logic [7:0] a, input logic [7:0] b);
        cyc(1'b1, a, 1'b0, 1'b0);
        cyc(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        resetn = 1'b1;
    endtask

    logic [7:0] byte_tab [12];

    initial begin
        logic [7:0] d;
        int         idx;
        byte_tab = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                     8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h5A, 8'hE0};
        resetn = 1'b0; ps2_key_pressed = 1'b0; ps2_key_data = 8'h00;
        flush = 1'b0; move_ready = 1'b0;
        do_reset();
        check("reset_valid", move_valid, 1'b0);
        check("reset_dir", move_dir, 2'b00);
        check("reset_count", fifo_count, 3'd0);
        check("reset_overflow", overflow, 1'b0);
        check("reset_start", start_pulse, 1'b0);

        // E0 75 -> up token one cycle after the 75 strobe
        key2(8'hE0, 8'h75);
        check("up_count_early", fifo_count, 3'd0);
        idle(1);
        check("up_valid", move_valid, 1'b1);
        check("up_dir", move_dir, 2'b00);
        check("up_count", fifo_count, 3'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);

        // typematic right x3, release, press again -> two tokens
        key2(8'hE0, 8'h74); key2(8'hE0, 8'h74); key2(8'hE0, 8'h74);
        cyc(1'b1, 8'hE0, 1'b0, 1'b0); key2(8'hF0, 8'h74);
        key2(8'hE0, 8'h74);
        idle(2);
        check("typematic_count", fifo_count, 3'd2);
        check("typematic_dir0", move_dir, 2'b11);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("typematic_dir1", move_dir, 2'b11);
        check("typematic_count1", fifo_count, 3'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // five alternating moves into a 4-deep FIFO -> overflow
        key2(8'hE0, 8'h75); key2(8'hE0, 8'h72); key2(8'hE0, 8'h75);
        key2(8'hE0, 8'h72); key2(8'hE0, 8'h75);
        idle(2);
        check("ovf_count", fifo_count, 3'd4);
        check("ovf_flag", overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_pop_dir", move_dir, (i % 2));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("ovf_drained", move_valid, 1'b0);
        check("ovf_sticky", overflow, 1'b1);

        // full FIFO with simultaneous pop and push -> no drop
        do_reset();
        key2(8'hE0, 8'h75); key2(8'hE0, 8'h72); key2(8'hE0, 8'h75); key2(8'hE0, 8'h72);
        idle(1);
        check("full_count", fifo_count, 3'd4);
        key2(8'hE0, 8'h6B);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("pp_count", fifo_count, 3'd4);
        check("pp_overflow", overflow, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("pp_pop_dir", move_dir, (i == 3) ? 2 : ((i % 2 == 0) ? 1 : 0));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("pp_drained", fifo_count, 3'd0);

        // flush after E0 discards the prefix
        cyc(1'b1, 8'hE0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h6B, 1'b0, 1'b0);
        idle(2);
        check("flush_count", fifo_count, 3'd0);
        key2(8'hE0, 8'h75);
        idle(1);
        check("flush_idle_dir", move_dir, 2'b00);
        check("flush_idle_count", fifo_count, 3'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // W then Enter
        cyc(1'b1, 8'h1D, 1'b0, 1'b0);
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        check("enter_pulse", start_pulse, 1'b1);
        idle(1);
        check("enter_pulse_end", start_pulse, 1'b0);
`ifdef PS2_MOVE_WASD_EN
        check("wasd_count", fifo_count, 3'd1);
        check("wasd_dir", move_dir, 2'b00);
`else
        check("wasd_count", fifo_count, 3'd0);
`endif

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) resetn = 1'b0;
            else resetn = 1'b1;
            idx = $urandom_range(0, 12);
            if (idx == 12) d = 8'($urandom);
            else d = byte_tab[idx];
            cyc(($urandom_range(0, 1) == 1), d, ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 149) == 0));
        end
        resetn = 1'b1;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
